// File: rtl/aclk_key_ctrl.sv
// Alarm clock keypad sequencer: collects key digits, issues alarm/time
// load strobes, selects display source, abandons entry on idle timeout.
module aclk_key_ctrl #(
    parameter int          TIMEOUT_SECS = 10,
    parameter logic [3:0]  NOKEY        = 4'd10
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       one_second,
    input  logic       alarm_button,
    input  logic       time_button,
    input  logic [3:0] key,
    output logic       load_new_alarm,
    output logic       load_new_time,
    output logic       show_new_time,
    output logic       show_a,
    output logic [3:0] key_ms_hr,
    output logic [3:0] key_ls_hr,
    output logic [3:0] key_ms_min,
    output logic [3:0] key_ls_min
);

    localparam int CW = $clog2(TIMEOUT_SECS + 1);

    typedef enum logic [2:0] {
        SHOW_TIME,
        KEY_STORED,
        KEY_WAIT,
        KEY_ENTRY,
        SHOW_ALARM,
        SET_ALARM_TIME,
        SET_CURRENT_TIME
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [15:0]     r_buf;
    logic [3:0]      r_key;
    logic [CW-1:0]   r_cnt;
    logic            w_valid;
    logic            w_timeout;
    logic            w_entry;

    assign w_valid   = (key <= 4'd9) && (key != NOKEY);
    assign w_timeout = (r_cnt == CW'(TIMEOUT_SECS));
    assign w_entry   = (r_state == KEY_WAIT) || (r_state == KEY_ENTRY);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= SHOW_TIME;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            SHOW_TIME: begin
                if (alarm_button)  w_next = SHOW_ALARM;
                else if (w_valid)  w_next = KEY_STORED;
            end
            KEY_STORED: w_next = KEY_WAIT;
            KEY_WAIT: begin
                if (!w_valid)       w_next = KEY_ENTRY;
                else if (w_timeout) w_next = SHOW_TIME;
            end
            KEY_ENTRY: begin
                if (alarm_button)     w_next = SET_ALARM_TIME;
                else if (time_button) w_next = SET_CURRENT_TIME;
                else if (w_valid)     w_next = KEY_STORED;
                else if (w_timeout)   w_next = SHOW_TIME;
            end
            SHOW_ALARM: begin
                if (!alarm_button) w_next = SHOW_TIME;
            end
            SET_ALARM_TIME:   w_next = SHOW_TIME;
            SET_CURRENT_TIME: w_next = SHOW_TIME;
            default:          w_next = SHOW_TIME;
        endcase
    end

    // Digits shift in on the KEY_STORED exit edge; any abandoned or
    // committed entry wipes the buffer on the way back to SHOW_TIME.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_buf <= '0;
            r_key <= '0;
        end else begin
            if (w_next == KEY_STORED) r_key <= key;
            if (r_state == KEY_STORED) begin
                r_buf <= {r_buf[11:0], r_key};
            end else if (r_state != SHOW_TIME && r_state != SHOW_ALARM
                         && w_next == SHOW_TIME) begin
                r_buf <= '0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (!w_entry) begin
            r_cnt <= '0;
        end else if (one_second && !w_timeout) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign load_new_alarm = (r_state == SET_ALARM_TIME);
    assign load_new_time  = (r_state == SET_CURRENT_TIME);
    assign show_new_time  = (r_state == KEY_STORED) || w_entry;
    assign show_a         = (r_state == SHOW_ALARM);
    assign key_ms_hr      = r_buf[15:12];
    assign key_ls_hr      = r_buf[11:8];
    assign key_ms_min     = r_buf[7:4];
    assign key_ls_min     = r_buf[3:0];

endmodule

// File: tb/tb_aclk_key_ctrl.sv
// Directed bench for aclk_key_ctrl: digit entry, load strobes, timeout,
// held/invalid keys, alarm display and async reset mid-entry.
module tb_aclk_key_ctrl;

    localparam int TS = 10;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       one_second = 1'b0;
    logic       alarm_button = 1'b0;
    logic       time_button = 1'b0;
    logic [3:0] key = 4'd10;
    logic       load_new_alarm;
    logic       load_new_time;
    logic       show_new_time;
    logic       show_a;
    logic [3:0] key_ms_hr;
    logic [3:0] key_ls_hr;
    logic [3:0] key_ms_min;
    logic [3:0] key_ls_min;

    int errs = 0;
    int checks = 0;
    int n_alarm = 0;
    int n_time = 0;
    int n_viol = 0;

    aclk_key_ctrl #(.TIMEOUT_SECS(TS), .NOKEY(4'd10)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .one_second     (one_second),
        .alarm_button   (alarm_button),
        .time_button    (time_button),
        .key            (key),
        .load_new_alarm (load_new_alarm),
        .load_new_time  (load_new_time),
        .show_new_time  (show_new_time),
        .show_a         (show_a),
        .key_ms_hr      (key_ms_hr),
        .key_ls_hr      (key_ls_hr),
        .key_ms_min     (key_ms_min),
        .key_ls_min     (key_ls_min)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (load_new_alarm) n_alarm++;
        if (load_new_time)  n_time++;
        if ((load_new_alarm && load_new_time) ||
            ((load_new_alarm || load_new_time) && (show_new_time || show_a)))
            n_viol++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        key = d;
        step(1);
        key = 4'd10;
        step(2);
    endtask

    task automatic tick();
        one_second = 1'b1;
        step(1);
        one_second = 1'b0;
    endtask

    function automatic logic [15:0] buf16();
        return {key_ms_hr, key_ls_hr, key_ms_min, key_ls_min};
    endfunction

    function automatic logic [3:0] flags();
        return {load_new_alarm, load_new_time, show_new_time, show_a};
    endfunction

    initial begin
        #2;
        chk("rst_flags", 32'(flags()), 32'h0);
        chk("rst_buf", 32'(buf16()), 32'h0);
        step(1);
        reset_n = 1'b1;
        step(1);

        press(4'd1);
        press(4'd2);
        chk("mid_buf", 32'(buf16()), 32'h0012);
        chk("mid_show", 32'(show_new_time), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_buf", 32'(buf16()), 32'h0);
        chk("async_rst_flags", 32'(flags()), 32'h0);
        step(1);
        reset_n = 1'b1;
        step(1);
        chk("post_rst_flags", 32'(flags()), 32'h0);

        press(4'd1);
        press(4'd2);
        press(4'd3);
        press(4'd0);
        chk("alarm_digits", 32'(buf16()), 32'h1230);
        alarm_button = 1'b1;
        step(1);
        chk("alarm_strobe", 32'(flags()), 32'h8);
        chk("alarm_buf", 32'(buf16()), 32'h1230);
        alarm_button = 1'b0;
        step(1);
        chk("alarm_done_flags", 32'(flags()), 32'h0);
        chk("alarm_done_buf", 32'(buf16()), 32'h0);
        chk("alarm_pulses", 32'(n_alarm), 32'd1);

        for (int d = 1; d <= 5; d++) press(4'(d));
        chk("five_digits", 32'(buf16()), 32'h2345);
        time_button = 1'b1;
        step(1);
        chk("time_strobe", 32'(flags()), 32'h4);
        chk("time_buf", 32'(buf16()), 32'h2345);
        time_button = 1'b0;
        step(1);
        chk("time_done_buf", 32'(buf16()), 32'h0);
        chk("time_pulses", 32'(n_time), 32'd1);

        key = 4'd7;
        step(20);
        chk("held_buf", 32'(buf16()), 32'h0007);
        chk("held_show", 32'(show_new_time), 32'h1);
        key = 4'd10;
        step(1);
        key = 4'd12;
        step(3);
        key = 4'd10;
        step(1);
        chk("key12_buf", 32'(buf16()), 32'h0007);
        time_button = 1'b1;
        step(1);
        chk("held_time_strobe", 32'(load_new_time), 32'h1);
        chk("held_time_buf", 32'(buf16()), 32'h0007);
        time_button = 1'b0;
        step(1);

        press(4'd4);
        repeat (TS - 1) tick();
        chk("pre_timeout_show", 32'(show_new_time), 32'h1);
        tick();
        chk("at_timeout_show", 32'(show_new_time), 32'h1);
        step(1);
        chk("timeout_flags", 32'(flags()), 32'h0);
        chk("timeout_buf", 32'(buf16()), 32'h0);

        press(4'd4);
        repeat (TS - 1) tick();
        press(4'd5);
        chk("restart_buf", 32'(buf16()), 32'h0045);
        repeat (TS - 1) tick();
        step(1);
        chk("restart_alive", 32'(show_new_time), 32'h1);
        tick();
        step(1);
        chk("restart_timeout", 32'(flags()), 32'h0);
        chk("restart_to_buf", 32'(buf16()), 32'h0);

        alarm_button = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("show_a_held", 32'(flags()), 32'h1);
        end
        alarm_button = 1'b0;
        step(1);
        chk("show_a_off", 32'(flags()), 32'h0);

        press(4'd9);
        alarm_button = 1'b1;
        time_button = 1'b1;
        step(1);
        chk("both_btn", 32'(flags()), 32'h8);
        alarm_button = 1'b0;
        time_button = 1'b0;
        step(1);
        chk("both_done", 32'(flags()), 32'h0);

        step(2);
        chk("total_alarm_pulses", 32'(n_alarm), 32'd2);
        chk("total_time_pulses", 32'(n_time), 32'd2);
        chk("exclusive_outputs", 32'(n_viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
